// File: rtl/ddr_init_seq_if.sv
// Memory command bus driven by the DDR power-up sequencer.
// The sequencer owns the bus (master) until initDone; observers use the slave view.
interface ddr_init_seq_if;
    logic        cke;
    logic        csN;
    logic        rasN;
    logic        casN;
    logic        weN;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        initDone;

    modport master (
        output cke, csN, rasN, casN, weN, ba, addr, initDone
    );

    modport slave (
        input  cke, csN, rasN, casN, weN, ba, addr, initDone
    );
endinterface

// File: rtl/ddr_init_seq.sv
// DDR SDRAM power-up / initialisation sequencer: CKE hold-off, PRECHARGE, EMR/MR loads,
// two AUTO REFRESHes, DLL lock wait, then a sticky initDone until the next reset.
module ddr_init_seq #(
    parameter int unsigned POWERUP_CYCLES = 26600,
    parameter int unsigned TRP            = 3,
    parameter int unsigned TMRD           = 2,
    parameter int unsigned TRFC           = 10,
    parameter int unsigned DLL_CYCLES     = 200,
    parameter logic [12:0] MODE_VALUE     = 13'h022,
    parameter logic [12:0] EMR_VALUE      = 13'h000
) (
    input  logic           clk,
    input  logic           rst,
    ddr_init_seq_if.master bus
);

    typedef enum logic [3:0] {
        ST_PWRUP   = 4'd0,
        ST_CKEHI   = 4'd1,
        ST_PRE1    = 4'd2,
        ST_EMR     = 4'd3,
        ST_MRRST   = 4'd4,
        ST_PRE2    = 4'd5,
        ST_REF1    = 4'd6,
        ST_REF2    = 4'd7,
        ST_MR      = 4'd8,
        ST_DLLWAIT = 4'd9,
        ST_DONE    = 4'd10
    } state_e;

    localparam logic [3:0]  CMD_NOP = 4'b0111;
    localparam logic [3:0]  CMD_PRE = 4'b0010;
    localparam logic [3:0]  CMD_REF = 4'b0001;
    localparam logic [3:0]  CMD_LMR = 4'b0000;

    localparam logic [15:0] PWR_LAST = 16'(POWERUP_CYCLES);
    localparam logic [15:0] TRP_M1   = 16'(TRP - 32'd1);
    localparam logic [15:0] TMRD_M1  = 16'(TMRD - 32'd1);
    localparam logic [15:0] TRFC_M1  = 16'(TRFC - 32'd1);
    localparam logic [15:0] DLL_SAT  = 16'(DLL_CYCLES);

    // Base mode register with the DLL-reset bit (A8) overridden.
    function automatic logic [12:0] mode_addr(input logic dll_rst);
        mode_addr = {MODE_VALUE[12:9], dll_rst, MODE_VALUE[7:0]};
    endfunction

    state_e      state_q,     state_d;
    logic [15:0] pwr_cnt_q,   pwr_cnt_d;
    logic [15:0] wait_q,      wait_d;
    logic [15:0] dll_cnt_q,   dll_cnt_d;
    logic        cke_q,       cke_d;
    logic [3:0]  cmd_q,       cmd_d;
    logic [1:0]  ba_q,        ba_d;
    logic [12:0] addr_q,      addr_d;
    logic        init_done_q, init_done_d;

    logic        wait_done_s;
    logic        dll_ok_s;
    logic        enter_s;

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PWRUP;
            pwr_cnt_q   <= 16'd0;
            wait_q      <= 16'd0;
            dll_cnt_q   <= 16'd0;
            cke_q       <= 1'b0;
            cmd_q       <= CMD_NOP;
            ba_q        <= 2'b00;
            addr_q      <= 13'd0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pwr_cnt_q   <= pwr_cnt_d;
            wait_q      <= wait_d;
            dll_cnt_q   <= dll_cnt_d;
            cke_q       <= cke_d;
            cmd_q       <= cmd_d;
            ba_q        <= ba_d;
            addr_q      <= addr_d;
            init_done_q <= init_done_d;
        end
    end

    // Next-state and counter logic; each command state holds for its full spacing.
    always_comb begin
        state_d     = state_q;
        pwr_cnt_d   = pwr_cnt_q;
        wait_d      = wait_q;
        dll_cnt_d   = dll_cnt_q;
        wait_done_s = (wait_q == 16'd0);

        // DLL counter runs from the DLL-reset load onwards and saturates.
        if ((state_q inside {ST_MRRST, ST_PRE2, ST_REF1, ST_REF2, ST_MR, ST_DLLWAIT, ST_DONE})
            && (dll_cnt_q < DLL_SAT)) begin
            dll_cnt_d = dll_cnt_q + 16'd1;
        end else begin
            dll_cnt_d = dll_cnt_q;
        end
        dll_ok_s = (dll_cnt_d >= DLL_SAT);

        case (state_q)
            ST_PWRUP: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    state_d = ST_CKEHI;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 16'd1;
                end
            end
            ST_CKEHI: begin
                state_d = ST_PRE1;
                wait_d  = TRP_M1;
            end
            ST_PRE1: begin
                if (wait_done_s) begin
                    state_d = ST_EMR;
                    wait_d  = TMRD_M1;
                end else begin
                    wait_d  = wait_q - 16'd1;
                end
            end
            ST_EMR: begin
                if (wait_done_s) begin
                    state_d   = ST_MRRST;
                    wait_d    = TMRD_M1;
                    dll_cnt_d = 16'd0;
                end else begin
                    wait_d    = wait_q - 16'd1;
                end
            end
            ST_MRRST: begin
                if (wait_done_s) begin
                    state_d = ST_PRE2;
                    wait_d  = TRP_M1;
                end else begin
                    wait_d  = wait_q - 16'd1;
                end
            end
            ST_PRE2: begin
                if (wait_done_s) begin
                    state_d = ST_REF1;
                    wait_d  = TRFC_M1;
                end else begin
                    wait_d  = wait_q - 16'd1;
                end
            end
            ST_REF1: begin
                if (wait_done_s) begin
                    state_d = ST_REF2;
                    wait_d  = TRFC_M1;
                end else begin
                    wait_d  = wait_q - 16'd1;
                end
            end
            ST_REF2: begin
                if (wait_done_s) begin
                    state_d = ST_MR;
                    wait_d  = TMRD_M1;
                end else begin
                    wait_d  = wait_q - 16'd1;
                end
            end
            ST_MR: begin
                if (wait_done_s) begin
                    state_d = dll_ok_s ? ST_DONE : ST_DLLWAIT;
                end else begin
                    wait_d  = wait_q - 16'd1;
                end
            end
            ST_DLLWAIT: begin
                if (dll_ok_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DLLWAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_PWRUP;
            end
        endcase
    end

    // Registered-output values: a command appears only on the cycle its state is entered.
    always_comb begin
        enter_s     = (state_d != state_q);
        cke_d       = (state_d != ST_PWRUP);
        cmd_d       = CMD_NOP;
        ba_d        = 2'b00;
        addr_d      = 13'd0;
        init_done_d = (state_d == ST_DONE);

        if (enter_s) begin
            case (state_d)
                ST_PRE1, ST_PRE2: begin
                    cmd_d  = CMD_PRE;
                    addr_d = 13'h0400;
                end
                ST_EMR: begin
                    cmd_d  = CMD_LMR;
                    ba_d   = 2'b01;
                    addr_d = EMR_VALUE;
                end
                ST_MRRST: begin
                    cmd_d  = CMD_LMR;
                    addr_d = mode_addr(1'b1);
                end
                ST_REF1, ST_REF2: begin
                    cmd_d  = CMD_REF;
                end
                ST_MR: begin
                    cmd_d  = CMD_LMR;
                    addr_d = mode_addr(1'b0);
                end
                default: begin
                    cmd_d  = CMD_NOP;
                end
            endcase
        end else begin
            cmd_d = CMD_NOP;
        end
    end

    assign bus.cke      = cke_q;
    assign bus.csN      = cmd_q[3];
    assign bus.rasN     = cmd_q[2];
    assign bus.casN     = cmd_q[1];
    assign bus.weN      = cmd_q[0];
    assign bus.ba       = ba_q;
    assign bus.addr     = addr_q;
    assign bus.initDone = init_done_q;

endmodule

// File: tb/tb_ddr_init_seq.sv
// Scoreboard bench for ddr_init_seq: three parameterisations share one reset stream,
// expectations come from a timeline model and are checked every cycle by a monitor.
module tb_ddr_init_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ddr_init_seq_if bus_a ();
    ddr_init_seq_if bus_b ();
    ddr_init_seq_if bus_c ();

    ddr_init_seq #(
        .POWERUP_CYCLES(10), .TRP(3), .TMRD(2), .TRFC(10), .DLL_CYCLES(200),
        .MODE_VALUE(13'h022), .EMR_VALUE(13'h000)
    ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    ddr_init_seq #(
        .POWERUP_CYCLES(10), .TRP(3), .TMRD(2), .TRFC(10), .DLL_CYCLES(1),
        .MODE_VALUE(13'h022), .EMR_VALUE(13'h000)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    ddr_init_seq #(
        .POWERUP_CYCLES(1), .TRP(1), .TMRD(1), .TRFC(1), .DLL_CYCLES(1),
        .MODE_VALUE(13'h022), .EMR_VALUE(13'h000)
    ) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    typedef struct packed {
        logic        cke;
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic        done;
    } obs_t;

    obs_t q_a[$];
    obs_t q_b[$];
    obs_t q_c[$];
    int   q_t[$];

    int   n_checks  = 0;
    int   n_fail    = 0;
    bit   stim_done = 1'b0;
    int   t         = -1;

    // Expected bus at cycle t after release (t < 0: held in reset), from the command timeline.
    function automatic obs_t model(input int p, input int trp, input int tmrd,
                                   input int trfc, input int dll, input int tc);
        obs_t o;
        int pre1, emr, mrrst, pre2, ref1, ref2, mr, done_at;
        o.cke  = 1'b0;
        o.cmd  = 4'b0111;
        o.ba   = 2'b00;
        o.addr = 13'h0000;
        o.done = 1'b0;
        if (tc >= 0) begin
            pre1    = p + 1;
            emr     = pre1 + trp;
            mrrst   = emr + tmrd;
            pre2    = mrrst + tmrd;
            ref1    = pre2 + trp;
            ref2    = ref1 + trfc;
            mr      = ref2 + trfc;
            done_at = (mr + tmrd > mrrst + dll) ? (mr + tmrd) : (mrrst + dll);
            o.cke   = (tc >= p);
            o.done  = (tc >= done_at);
            if (tc == pre1 || tc == pre2) begin
                o.cmd = 4'b0010; o.addr = 13'h0400;
            end else if (tc == emr) begin
                o.cmd = 4'b0000; o.ba = 2'b01; o.addr = 13'h0000;
            end else if (tc == mrrst) begin
                o.cmd = 4'b0000; o.addr = 13'h0122;
            end else if (tc == ref1 || tc == ref2) begin
                o.cmd = 4'b0001;
            end else if (tc == mr) begin
                o.cmd = 4'b0000; o.addr = 13'h0022;
            end
        end
        return o;
    endfunction

    // Drive rst for the coming edge and queue what each DUT must show after it.
    task automatic step(input logic r);
        rst = r;
        if (r) t = -1;
        else   t = t + 1;
        q_a.push_back(model(10, 3, 2, 10, 200, t));
        q_b.push_back(model(10, 3, 2, 10, 1,   t));
        q_c.push_back(model(1,  1, 1, 1,  1,   t));
        q_t.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int tc, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got cke=%b cmd=%b ba=%b addr=%h done=%b expected cke=%b cmd=%b ba=%b addr=%h done=%b",
                     name, tc, act.cke, act.cmd, act.ba, act.addr, act.done,
                     exp.cke, exp.cmd, exp.ba, exp.addr, exp.done);
        end
    endtask

    function automatic obs_t sample_a();
        return {bus_a.cke, bus_a.csN, bus_a.rasN, bus_a.casN, bus_a.weN,
                bus_a.ba, bus_a.addr, bus_a.initDone};
    endfunction
    function automatic obs_t sample_b();
        return {bus_b.cke, bus_b.csN, bus_b.rasN, bus_b.casN, bus_b.weN,
                bus_b.ba, bus_b.addr, bus_b.initDone};
    endfunction
    function automatic obs_t sample_c();
        return {bus_c.cke, bus_c.csN, bus_c.rasN, bus_c.casN, bus_c.weN,
                bus_c.ba, bus_c.addr, bus_c.initDone};
    endfunction

    // Stimulus: nominal run, reset during REF1 wait, reset in DONE, long reset, random pulses.
    initial begin
        int k;
        repeat (3) step(1'b1);
        repeat (230) step(1'b0);

        repeat (2) step(1'b1);
        k = int'($urandom_range(30, 22));
        repeat (k) step(1'b0);
        step(1'b1);
        repeat (230) step(1'b0);

        step(1'b1);
        repeat (230) step(1'b0);

        repeat (500) step(1'b1);
        repeat (230) step(1'b0);

        repeat (6) begin
            repeat (int'($urandom_range(3, 1))) step(1'b1);
            repeat (int'($urandom_range(250, 1))) step(1'b0);
        end
        step(1'b1);
        repeat (230) step(1'b0);
        stim_done = 1'b1;
    end

    // Monitor: every cycle the bus is live, pop one expectation per DUT and compare.
    initial begin
        obs_t ea, eb, ec;
        int   tc;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(posedge clk);
            #2;
            if (q_a.size() == 0) begin
                if (stim_done) break;
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty cyc=%0d got 0 entries expected at least 1", cyc);
                continue;
            end
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            ec = q_c.pop_front();
            tc = q_t.pop_front();
            check("nominal_dll200", tc, sample_a(), ea);
            check("short_dll1",     tc, sample_b(), eb);
            check("all_waits_1",    tc, sample_c(), ec);
        end
        if (!stim_done || q_a.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_timeout got stim_done=%0d pending=%0d expected stim_done=1 pending=0",
                     stim_done, q_a.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_init_seq.md
Name: ddr_init_seq

Overview:
- Consumer side of the clock/reset generator: leaves reset once the 133 MHz clock tree is locked and the debounced reset has cleared.
- Drives the DDR SDRAM JEDEC power-up and initialisation command sequence on the memory command bus.
- Asserts `initDone` when the device is ready for the read/write controller.
- Once `initDone` is set, the controller muxes the command bus over to normal operation; this block stays idle until the next reset.

Parameters:
- POWERUP_CYCLES, 26600, cycles with CKE low after reset (200 us at 133 MHz); range 1..65535
- TRP, 3, precharge period in cycles (command-to-command spacing after PRECHARGE); range 1..65535
- TMRD, 2, mode-register-set spacing in cycles; range 1..65535
- TRFC, 10, auto-refresh period in cycles; range 1..65535
- DLL_CYCLES, 200, minimum cycles from the DLL-reset LOAD MODE to `initDone`; range 1..65535
- MODE_VALUE, 13'h022, base mode register: burst length 4, sequential, CAS latency 2
- EMR_VALUE, 13'h000, extended mode register: DLL enable, normal drive

Ports:
- clk  in  1  system clock (133 MHz domain)
- rst  in  1  synchronous reset, active-high
- cke  out  1  SDRAM clock enable
- csN  out  1  chip select, active-low
- rasN  out  1  row address strobe, active-low
- casN  out  1  column address strobe, active-low
- weN  out  1  write enable, active-low
- ba  out  2  bank address
- addr  out  13  address bus
- initDone  out  1  sequence complete; sticky until `rst`

Behaviour:
- Command encoding {csN,rasN,casN,weN}:
  - NOP = 0111
  - PRECHARGE = 0010
  - AUTO REFRESH = 0001
  - LOAD MODE = 0000
- All outputs are registered.
- Reset values, and values while `rst` is high: cke=0, cmd=NOP, ba=0, addr=0, initDone=0, FSM=PWRUP, counters cleared.
- Reset is synchronous only. When `rst` is sampled high on a rising edge, the outputs take their reset values at that edge, from any state including mid-sequence and DONE. The sequence then restarts from the beginning.
- Cycle 0 is the first edge at which `rst` is sampled low.
- Each command is driven for exactly one cycle. The wait parameter N that follows a command means the next command is issued exactly N cycles later. All intervening cycles drive NOP, with ba and addr held at 0.
- FSM states and transitions (P = POWERUP_CYCLES):
  - PWRUP: cycles 0..P-1; cke=0, NOP.
  - CKEHI: cycle P; cke=1, NOP. cke stays 1 from here until reset.
  - PRE1: PRECHARGE with addr[10]=1 (all banks), ba=0; then wait TRP.
  - EMR: LOAD MODE, ba=2'b01, addr=EMR_VALUE; then wait TMRD.
  - MRRST: LOAD MODE, ba=2'b00, addr=MODE_VALUE with addr[8] forced to 1 (DLL reset); then wait TMRD. The DLL counter starts at 0 on this cycle.
  - PRE2: PRECHARGE all, as in PRE1; then wait TRP.
  - REF1: AUTO REFRESH; then wait TRFC.
  - REF2: AUTO REFRESH; then wait TRFC.
  - MR: LOAD MODE, ba=2'b00, addr=MODE_VALUE with addr[8] forced to 0; then wait TMRD.
  - DLLWAIT: NOP until both conditions hold:
    - the DLL counter reaches DLL_CYCLES, i.e. the current cycle is at or after MRRST cycle + DLL_CYCLES;
    - the MR wait has expired.
    initDone rises on the first cycle both hold.
  - DONE: initDone=1, cke=1, NOP forever; no refreshes are issued.
- Wait counter: 16-bit, loaded with N-1 when a command issues, counts down to 0. N=1 means back-to-back commands.
- DLL counter: 16-bit, saturates at DLL_CYCLES, no wrap.
- With the test parameters (P=10, TRP=3, TMRD=2, TRFC=10, DLL=200), the sequence runs:
  - cke 0→1 at cycle 10
  - PRE 11, EMR 14, MRRST 16, PRE 18, REF 21, REF 31, MR 41
  - initDone at cycle 216
- If DLL_CYCLES is short, initDone is instead governed by the MR wait: cycle = MR + TMRD.
- Exactly 7 non-NOP commands are issued per initialisation.

Test Plan:
- Nominal sequence, params P=10/TRP=3/TMRD=2/TRFC=10/DLL=200; release rst at cycle 0:
  - cke=0 on cycles 0-9, 1 from cycle 10
  - PRE@11 addr=13'h400, EMR@14 ba=1 addr=0, MRRST@16 ba=0 addr=13'h122, PRE@18, REF@21, REF@31, MR@41 addr=13'h022
  - NOP on every other cycle; initDone=1 from cycle 216 on
- DLL_CYCLES=1, same other params: initDone rises at cycle 43 (MR + TMRD), not earlier.
- All wait parameters = 1, P=1: commands on consecutive cycles 2..8, initDone at cycle 9.
- Assert rst for 1 cycle during REF1's wait:
  - next edge shows cke=0, NOP, initDone=0
  - the full nominal timeline repeats, referenced to the new release.
- Assert rst for 1 cycle while in DONE: initDone drops, cke=0, and the sequence repeats identically.
- Hold rst high for 500 cycles: outputs stay at reset values throughout, with no commands issued.
